// File: rtl/rf_wb_pkg.sv
// Shared types and default sizing for the register-file writeback path.
// Both writeback sources (ALU and LSU) use these definitions.
package rf_wb_pkg;

    localparam int RF_DEPTH = 32;
    localparam int RF_WIDTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    // Bit position of each source in the arbiter request/grant vectors.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                valid;
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins. When both
// request, the pointer owner wins. The pointer then moves to the other requester.
module rr_arb2
    import rf_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    wb_src_e ptr_reg;
    wb_src_e ptr_next;

    always_comb begin
        grant    = req;
        ptr_next = ptr_reg;
        if (req == 2'b11) begin
            grant = (ptr_reg == SRC_ALU) ? 2'b01 : 2'b10;
        end
        if (grant[SRC_ALU]) begin
            ptr_next = SRC_LSU;
        end else if (grant[SRC_LSU]) begin
            ptr_next = SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_reg <= SRC_ALU;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the ALU and LSU writebacks.
// Stages the winner for one cycle and exposes the stage as a forwarding tap.
module rf_write_arbiter
    import rf_wb_pkg::*;
#(
    parameter  int DEPTH = RF_DEPTH,
    parameter  int WIDTH = RF_WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ALU_VALID,
    input  logic [AW-1:0]    ALU_A,
    input  logic [WIDTH-1:0] ALU_WD,
    output logic             ALU_READY,
    input  logic             LSU_VALID,
    input  logic [AW-1:0]    LSU_A,
    input  logic [WIDTH-1:0] LSU_WD,
    output logic             LSU_READY,
    output logic             WE3,
    output logic [AW-1:0]    A3,
    output logic [WIDTH-1:0] WD3,
    output logic             FWD_VALID,
    output logic [AW-1:0]    FWD_A,
    output logic [WIDTH-1:0] FWD_WD
);

    logic [1:0]       req;
    logic [1:0]       grant;
    logic             stage_valid_reg, stage_valid_next;
    logic [AW-1:0]    stage_addr_reg, stage_addr_next;
    logic [WIDTH-1:0] stage_data_reg, stage_data_next;
    logic             stage_live;

    // Requests are hidden from the arbiter during reset so that no READY
    // is raised and no grant is taken.
    assign req = {LSU_VALID, ALU_VALID} & {2{RSTn}};

    rr_arb2 u_arb (
        .clk   (CLK),
        .rstn  (RSTn),
        .req   (req),
        .grant (grant)
    );

    assign ALU_READY = grant[SRC_ALU];
    assign LSU_READY = grant[SRC_LSU];

    always_comb begin
        stage_valid_next = |grant;
        stage_addr_next  = stage_addr_reg;
        stage_data_next  = stage_data_reg;
        if (grant[SRC_ALU]) begin
            stage_addr_next = ALU_A;
            stage_data_next = ALU_WD;
        end else if (grant[SRC_LSU]) begin
            stage_addr_next = LSU_A;
            stage_data_next = LSU_WD;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stage_valid_reg <= 1'b0;
            stage_addr_reg  <= '0;
            stage_data_reg  <= '0;
        end else begin
            stage_valid_reg <= stage_valid_next;
            stage_addr_reg  <= stage_addr_next;
            stage_data_reg  <= stage_data_next;
        end
    end

    // RSTn is in this term so that asserting reset squashes a staged write
    // in the same cycle, before it can commit at the next edge.
    assign stage_live = stage_valid_reg & RSTn;

    // Register 0 is hard-wired to zero. Writes to it are staged but never enabled.
    assign WE3 = stage_live & (stage_addr_reg != '0);
    assign A3  = stage_live ? stage_addr_reg : '0;
    assign WD3 = stage_live ? stage_data_reg : '0;

    assign FWD_VALID = WE3;
    assign FWD_A     = A3;
    assign FWD_WD    = WD3;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed checks of rf_write_arbiter against a behavioural
// model made of an arbitration pointer, a one-entry stage and a register-file array.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rstn;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_a, lsu_a;
    logic [31:0] alu_wd, lsu_wd;
    logic        alu_ready, lsu_ready;
    logic        we3, fwd_valid;
    logic [4:0]  a3, fwd_a;
    logic [31:0] wd3, fwd_wd;

    rf_write_arbiter dut (
        .CLK       (clk),
        .RSTn      (rstn),
        .ALU_VALID (alu_valid),
        .ALU_A     (alu_a),
        .ALU_WD    (alu_wd),
        .ALU_READY (alu_ready),
        .LSU_VALID (lsu_valid),
        .LSU_A     (lsu_a),
        .LSU_WD    (lsu_wd),
        .LSU_READY (lsu_ready),
        .WE3       (we3),
        .A3        (a3),
        .WD3       (wd3),
        .FWD_VALID (fwd_valid),
        .FWD_A     (fwd_a),
        .FWD_WD    (fwd_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;

    // Model state: who wins a tie next, and what is waiting to commit.
    int          ptr;
    bit          m_sv;
    logic [4:0]  m_sa;
    logic [31:0] m_swd;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];
    bit          exp_ra, exp_rl;
    bit          got_a, got_l;
    int          alu_wait, lsu_wait;
    logic [31:0] saved7;
    logic [4:0]  seq [4] = '{5'd1, 5'd3, 5'd2, 5'd4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Compare every output with the model on the falling edge.
    task automatic sample();
        bit          live, exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_wd;
        @(negedge clk);
        exp_ra = rstn && alu_valid && (!lsu_valid || ptr == 0);
        exp_rl = rstn && lsu_valid && (!alu_valid || ptr == 1);
        live   = rstn && m_sv;
        exp_we = live && (m_sa != 5'd0);
        exp_a  = live ? m_sa : 5'd0;
        exp_wd = live ? m_swd : 32'd0;
        chk("alu_ready", alu_ready, exp_ra);
        chk("lsu_ready", lsu_ready, exp_rl);
        chk("we3", we3, exp_we);
        chk("a3", a3, exp_a);
        chk("wd3", wd3, exp_wd);
        chk("fwd_valid", fwd_valid, exp_we);
        chk("fwd_a", fwd_a, exp_a);
        chk("fwd_wd", fwd_wd, exp_wd);
        if (we3) dut_rf[a3] = wd3;
        if (exp_we) model_rf[m_sa] = m_swd;
        got_a = alu_ready;
        got_l = lsu_ready;
    endtask

    // Apply the rising edge to the model.
    task automatic advance();
        @(posedge clk);
        if (!rstn) begin
            m_sv = 0;
            ptr  = 0;
        end else if (exp_ra) begin
            m_sv = 1; m_sa = alu_a; m_swd = alu_wd; ptr = 1;
        end else if (exp_rl) begin
            m_sv = 1; m_sa = lsu_a; m_swd = lsu_wd; ptr = 0;
        end else begin
            m_sv = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 0;
        lsu_valid = 0;
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    initial begin
        ptr = 0; m_sv = 0; m_sa = '0; m_swd = '0;
        alu_wait = 0; lsu_wait = 0;
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        rstn = 0;
        alu_valid = 1; alu_a = 5'd1; alu_wd = 32'h11;
        lsu_valid = 1; lsu_a = 5'd3; lsu_wd = 32'h33;

        // Reset held with both requesting.
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_alu_ready", alu_ready, 0);
            chk("rst_lsu_ready", lsu_ready, 0);
            chk("rst_we3", we3, 0);
            chk("rst_a3", a3, 0);
            chk("rst_wd3", wd3, 0);
            advance();
        end
        rstn = 1;
        sample();
        chk("first_grant_alu", alu_ready, 1);
        chk("first_grant_lsu", lsu_ready, 0);
        advance();
        idle(3);

        // ALU alone.
        alu_valid = 1; alu_a = 5'd5; alu_wd = 32'hDEADBEEF;
        sample();
        chk("alu_alone_ready", alu_ready, 1);
        advance();
        alu_valid = 0;
        sample();
        chk("alu_alone_we3", we3, 1);
        chk("alu_alone_a3", a3, 5);
        chk("alu_alone_wd3", wd3, 32'hDEADBEEF);
        chk("alu_alone_fwd", fwd_valid, 1);
        advance();

        // Contention from a freshly reset pointer.
        rstn = 0;
        sample();
        advance();
        rstn = 1;
        begin
            int ai, li;
            ai = 0; li = 0;
            for (int c = 0; c < 6; c++) begin
                alu_valid = (ai < 2); alu_a = (ai == 0) ? 5'd1 : 5'd2; alu_wd = 32'(alu_a) * 17;
                lsu_valid = (li < 2); lsu_a = (li == 0) ? 5'd3 : 5'd4; lsu_wd = 32'(lsu_a) * 17;
                sample();
                if (c >= 1 && c <= 4) chk("contention_a3", a3, seq[c-1]);
                advance();
                if (got_a) ai++;
                if (got_l) li++;
            end
        end
        idle(1);

        // Write to register 0 is accepted but never enabled.
        lsu_valid = 1; lsu_a = 5'd0; lsu_wd = 32'h1234;
        sample();
        chk("x0_ready", lsu_ready, 1);
        advance();
        lsu_valid = 0;
        sample();
        chk("x0_we3", we3, 0);
        chk("x0_fwd_valid", fwd_valid, 0);
        advance();
        chk("x0_rf0", dut_rf[0], 0);

        // Reset arriving the cycle after a grant.
        saved7 = dut_rf[7];
        alu_valid = 1; alu_a = 5'd7; alu_wd = 32'h77;
        sample();
        advance();
        alu_valid = 0; rstn = 0;
        sample();
        chk("midrst_we3", we3, 0);
        advance();
        rstn = 1;
        idle(2);
        chk("midrst_rf7", dut_rf[7], saved7);

        // Same destination from both sources on consecutive cycles.
        alu_valid = 1; alu_a = 5'd9; alu_wd = 32'd1;
        sample();
        advance();
        alu_valid = 0;
        lsu_valid = 1; lsu_a = 5'd9; lsu_wd = 32'd2;
        sample();
        chk("race_fwd_wd_first", fwd_wd, 1);
        advance();
        lsu_valid = 0;
        sample();
        chk("race_fwd_wd_second", fwd_wd, 2);
        advance();
        idle(1);
        chk("race_rf9", dut_rf[9], 2);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 39) != 0);
            sample();
            if (rstn && alu_valid && !got_a) alu_wait++; else alu_wait = 0;
            if (rstn && lsu_valid && !got_l) lsu_wait++; else lsu_wait = 0;
            chk("alu_wait_bound", 32'(alu_wait <= 1), 1);
            chk("lsu_wait_bound", 32'(lsu_wait <= 1), 1);
            advance();
            if (alu_valid && got_a) alu_valid = 0;
            if (lsu_valid && got_l) lsu_valid = 0;
            if (!alu_valid && $urandom_range(0, 9) < 6) begin
                alu_valid = 1; alu_a = 5'($urandom_range(0, 31)); alu_wd = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 9) < 6) begin
                lsu_valid = 1; lsu_a = 5'($urandom_range(0, 31)); lsu_wd = $urandom;
            end
        end
        rstn = 1;
        idle(2);
        for (int i = 0; i < 32; i++) chk("rf_contents", dut_rf[i], model_rf[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
